// File: rtl/seg7_scan_ctrl.sv
// Round-robin seven-segment scan controller: dwell per enabled digit, blanking tail,
// hex decode with decimal point. All pins are registered.
module seg7_scan_ctrl #(
    parameter int unsigned CLK_MHZ   = 100,
    parameter int unsigned DIGIT     = 4,
    parameter int unsigned SCAN_HZ   = 1000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [4*DIGIT-1:0]       value,
    input  logic [DIGIT-1:0]         dp,
    input  logic [DIGIT-1:0]         en_mask,
    output logic [7:0]               abcdefgh,
    output logic [DIGIT-1:0]         digit,
    output logic [$clog2(DIGIT)-1:0] cur_idx
);

    localparam int unsigned DWELL = CLK_MHZ * 1_000_000 / SCAN_HZ;
    localparam int unsigned CNT_W = $clog2(DWELL);
    localparam int unsigned IDX_W = $clog2(DIGIT);
    localparam logic [CNT_W-1:0] LIT_LAST   = CNT_W'(DWELL - BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [IDX_W-1:0] idx_n, low_idx, adv_idx;
    logic [3:0]       nib, nib_n;
    logic             dp_lat, dp_n;
    logic [7:0]       seg_n;
    logic [DIGIT-1:0] dig_n;
    logic             adv, take, adv_found;

    function automatic logic [7:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 8'hFC;  4'h1: decode = 8'h60;
            4'h2: decode = 8'hDA;  4'h3: decode = 8'hF2;
            4'h4: decode = 8'h66;  4'h5: decode = 8'hB6;
            4'h6: decode = 8'hBE;  4'h7: decode = 8'hE0;
            4'h8: decode = 8'hFE;  4'h9: decode = 8'hF6;
            4'hA: decode = 8'hEE;  4'hB: decode = 8'h3E;
            4'hC: decode = 8'h9C;  4'hD: decode = 8'h7A;
            4'hE: decode = 8'h9E;  default: decode = 8'h8E;
        endcase
    endfunction

    // Lowest set mask bit (IDLE exit) and next set bit after cur_idx, wrapping (ADVANCE)
    always_comb begin
        low_idx   = '0;
        adv_idx   = cur_idx;
        adv_found = 1'b0;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            if (en_mask[DIGIT-1-i]) low_idx = IDX_W'(DIGIT - 1 - i);
        end
        for (int unsigned k = 1; k <= DIGIT; k++) begin
            if (!adv_found && en_mask[(32'(cur_idx) + k) % DIGIT]) begin
                adv_found = 1'b1;
                adv_idx   = IDX_W'((32'(cur_idx) + k) % DIGIT);
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = cur_idx;
        nib_n   = nib;
        dp_n    = dp_lat;
        adv     = 1'b0;
        take    = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (enable && |en_mask) begin
                    state_n = SHOW;
                    idx_n   = low_idx;
                    take    = 1'b1;
                end
            end
            SHOW: begin
                if (!enable) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == LIT_LAST) begin
                    if (BLANK_CYC > 0) begin
                        state_n = BLANK;
                        cnt_n   = cnt + CNT_W'(1);
                    end else begin
                        adv = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            BLANK: begin
                if (!enable) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == DWELL_LAST) begin
                    adv = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        if (adv) begin
            cnt_n = '0;
            if (adv_found) begin
                state_n = SHOW;
                idx_n   = adv_idx;
                take    = 1'b1;
            end else begin
                state_n = IDLE;
            end
        end
        if (take) begin
            nib_n = value[{idx_n, 2'b00} +: 4];
            dp_n  = dp[idx_n];
        end
        // Pin values are derived from the next state so they change on the transition edge
        seg_n = '0;
        dig_n = '0;
        if (state_n == SHOW) begin
            seg_n = decode(nib_n) | {7'b0, dp_n};
            dig_n = DIGIT'(1) << idx_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            cur_idx  <= '0;
            nib      <= '0;
            dp_lat   <= 1'b0;
            abcdefgh <= '0;
            digit    <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            cur_idx  <= idx_n;
            nib      <= nib_n;
            dp_lat   <= dp_n;
            abcdefgh <= seg_n;
            digit    <= dig_n;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: per-cycle expected pin values queued from the
// scan schedule, popped and compared one cycle at a time.
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable, enable_b;
    logic [15:0] value, value_b;
    logic [3:0]  dp, dp_b, en_mask, en_mask_b;
    logic [7:0]  abcdefgh, abcdefgh_b;
    logic [3:0]  digit, digit_b;
    logic [1:0]  cur_idx, cur_idx_b;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.CLK_MHZ(1), .DIGIT(4), .SCAN_HZ(100_000), .BLANK_CYC(2)) dut (
        .clk(clk), .rst(rst), .enable(enable), .value(value), .dp(dp),
        .en_mask(en_mask), .abcdefgh(abcdefgh), .digit(digit), .cur_idx(cur_idx)
    );

    seg7_scan_ctrl #(.CLK_MHZ(1), .DIGIT(4), .SCAN_HZ(100_000), .BLANK_CYC(0)) dut_nb (
        .clk(clk), .rst(rst), .enable(enable_b), .value(value_b), .dp(dp_b),
        .en_mask(en_mask_b), .abcdefgh(abcdefgh_b), .digit(digit_b), .cur_idx(cur_idx_b)
    );

    typedef struct {
        logic [3:0] dig;
        logic [7:0] seg;
        int         idx;   // -1: cur_idx not checked
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push_turn(input int d, input logic [7:0] seg, input int lit, input int blank);
        exp_t e;
        for (int i = 0; i < lit; i++) begin
            e.dig = 4'(1 << d); e.seg = seg; e.idx = d;
            sb.push_back(e);
        end
        for (int i = 0; i < blank; i++) begin
            e.dig = 4'b0; e.seg = 8'h00; e.idx = d;
            sb.push_back(e);
        end
    endtask

    task automatic push_idle(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.dig = 4'b0; e.seg = 8'h00; e.idx = -1;
            sb.push_back(e);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; enable = 1'b0; enable_b = 1'b0;
        en_mask = '0; en_mask_b = '0; value = '0; value_b = '0; dp = '0; dp_b = '0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 1'b0; enable_b = 1'b0;
        en_mask = 4'hF; en_mask_b = '0; value = 16'h3210; value_b = '0; dp = '0; dp_b = '0;
        #1;
        checks++;
        if (digit !== 4'b0) begin errors++; $display("FAIL reset_digit: got %b want 0000", digit); end
        checks++;
        if (abcdefgh !== 8'h00) begin errors++; $display("FAIL reset_seg: got %h want 00", abcdefgh); end
        checks++;
        if (cur_idx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", cur_idx); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (digit !== 4'b0 || abcdefgh !== 8'h00) begin
            errors++; $display("FAIL idle_disabled: digit=%b seg=%h want 0000/00", digit, abcdefgh);
        end
    endtask

    task automatic test_full_rotation();
        exp_t e;
        int   n = 0;
        do_reset();
        en_mask = 4'hF; value = 16'h3210; dp = 4'h0; enable = 1'b1;
        for (int r = 0; r < 2; r++) begin
            push_turn(0, 8'hFC, 8, 2); push_turn(1, 8'h60, 8, 2);
            push_turn(2, 8'hDA, 8, 2); push_turn(3, 8'hF2, 8, 2);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            checks++;
            if (digit !== e.dig || abcdefgh !== e.seg || (e.idx >= 0 && cur_idx !== 2'(e.idx))) begin
                errors++;
                $display("FAIL rotation cyc %0d: digit=%b seg=%h idx=%0d want digit=%b seg=%h idx=%0d",
                         n, digit, abcdefgh, cur_idx, e.dig, e.seg, e.idx);
            end
            n++;
        end
    endtask

    task automatic test_masked_skip();
        exp_t e;
        int   n = 0;
        do_reset();
        en_mask = 4'b1010; value = 16'hF0A0; dp = 4'b1000; enable = 1'b1;
        for (int r = 0; r < 2; r++) begin
            push_turn(1, 8'hEE, 8, 2); push_turn(3, 8'h8F, 8, 2);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            checks++;
            if (digit !== e.dig || abcdefgh !== e.seg || (e.idx >= 0 && cur_idx !== 2'(e.idx))) begin
                errors++;
                $display("FAIL masked_skip cyc %0d: digit=%b seg=%h idx=%0d want digit=%b seg=%h idx=%0d",
                         n, digit, abcdefgh, cur_idx, e.dig, e.seg, e.idx);
            end
            n++;
        end
    endtask

    task automatic test_mid_dwell_update();
        exp_t e;
        int   n = 0;
        do_reset();
        en_mask = 4'hF; value = 16'h3210; dp = 4'h0; enable = 1'b1;
        push_turn(0, 8'hFC, 8, 2); push_turn(1, 8'h60, 8, 2);
        push_turn(2, 8'hDA, 8, 2); push_turn(3, 8'hF2, 8, 2);
        push_turn(0, 8'h60, 8, 2);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            checks++;
            if (digit !== e.dig || abcdefgh !== e.seg || (e.idx >= 0 && cur_idx !== 2'(e.idx))) begin
                errors++;
                $display("FAIL mid_dwell cyc %0d: digit=%b seg=%h idx=%0d want digit=%b seg=%h idx=%0d",
                         n, digit, abcdefgh, cur_idx, e.dig, e.seg, e.idx);
            end
            if (n == 2) value[3:0] = 4'h1;
            n++;
        end
    endtask

    task automatic test_disable_restart();
        exp_t e;
        int   n = 0;
        do_reset();
        en_mask = 4'hF; value = 16'h3210; dp = 4'h0; enable = 1'b1;
        push_turn(0, 8'hFC, 8, 2); push_turn(1, 8'h60, 8, 2); push_turn(2, 8'hDA, 8, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            checks++;
            if (digit !== e.dig || abcdefgh !== e.seg || (e.idx >= 0 && cur_idx !== 2'(e.idx))) begin
                errors++;
                $display("FAIL disable_pre cyc %0d: digit=%b seg=%h want digit=%b seg=%h",
                         n, digit, abcdefgh, e.dig, e.seg);
            end
            n++;
        end
        enable = 1'b0;
        push_idle(3);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            checks++;
            if (digit !== e.dig || abcdefgh !== e.seg) begin
                errors++;
                $display("FAIL disable_idle cyc %0d: digit=%b seg=%h want 0000/00", n, digit, abcdefgh);
            end
            n++;
        end
        en_mask = 4'b0100; enable = 1'b1;
        push_turn(2, 8'hDA, 8, 2); push_turn(2, 8'hDA, 8, 2);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            checks++;
            if (digit !== e.dig || abcdefgh !== e.seg || (e.idx >= 0 && cur_idx !== 2'(e.idx))) begin
                errors++;
                $display("FAIL restart cyc %0d: digit=%b seg=%h idx=%0d want digit=%b seg=%h idx=%0d",
                         n, digit, abcdefgh, cur_idx, e.dig, e.seg, e.idx);
            end
            n++;
        end
    endtask

    task automatic test_mask_to_zero();
        exp_t e;
        int   n = 0;
        do_reset();
        en_mask = 4'hF; value = 16'h3210; dp = 4'h0; enable = 1'b1;
        push_turn(0, 8'hFC, 8, 2); push_turn(1, 8'h60, 8, 2); push_idle(6);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            checks++;
            if (digit !== e.dig || abcdefgh !== e.seg || (e.idx >= 0 && cur_idx !== 2'(e.idx))) begin
                errors++;
                $display("FAIL mask_zero cyc %0d: digit=%b seg=%h idx=%0d want digit=%b seg=%h idx=%0d",
                         n, digit, abcdefgh, cur_idx, e.dig, e.seg, e.idx);
            end
            if (n == 10) en_mask = 4'b0000;
            n++;
        end
    endtask

    task automatic test_no_blank();
        exp_t e;
        int   n = 0;
        do_reset();
        en_mask_b = 4'b0001; value_b = 16'h0008; dp_b = 4'h0; enable_b = 1'b1;
        push_turn(0, 8'hFE, 35, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            checks++;
            if (digit_b !== e.dig || abcdefgh_b !== e.seg || cur_idx_b !== 2'(e.idx)) begin
                errors++;
                $display("FAIL no_blank cyc %0d: digit=%b seg=%h idx=%0d want digit=%b seg=%h idx=%0d",
                         n, digit_b, abcdefgh_b, cur_idx_b, e.dig, e.seg, e.idx);
            end
            n++;
        end
        enable_b = 1'b0;
    endtask

    task automatic test_async_reset();
        exp_t e;
        int   n = 0;
        do_reset();
        en_mask = 4'hF; value = 16'h3210; dp = 4'h0; enable = 1'b1;
        push_turn(0, 8'hFC, 8, 2); push_turn(1, 8'h60, 3, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            checks++;
            if (digit !== e.dig || abcdefgh !== e.seg) begin
                errors++;
                $display("FAIL async_pre cyc %0d: digit=%b seg=%h want digit=%b seg=%h",
                         n, digit, abcdefgh, e.dig, e.seg);
            end
            n++;
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (digit !== 4'b0) begin errors++; $display("FAIL async_digit: got %b want 0000", digit); end
        checks++;
        if (abcdefgh !== 8'h00) begin errors++; $display("FAIL async_seg: got %h want 00", abcdefgh); end
        checks++;
        if (cur_idx !== 2'd0) begin errors++; $display("FAIL async_idx: got %0d want 0", cur_idx); end
        #1 rst = 1'b1;
        push_turn(0, 8'hFC, 8, 2); push_turn(1, 8'h60, 8, 2);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            checks++;
            if (digit !== e.dig || abcdefgh !== e.seg || (e.idx >= 0 && cur_idx !== 2'(e.idx))) begin
                errors++;
                $display("FAIL async_restart cyc %0d: digit=%b seg=%h idx=%0d want digit=%b seg=%h idx=%0d",
                         n, digit, abcdefgh, cur_idx, e.dig, e.seg, e.idx);
            end
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_full_rotation();
        test_masked_skip();
        test_mid_dwell_update();
        test_disable_restart();
        test_mask_to_zero();
        test_no_blank();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
